// File: rtl/b01_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : b01_pkg
//  Description : Shared types, default sizes and helpers for the b01 stream
//                packer (assembly state encoding, saturating increment).
//  Revision    : 1.0 - initial release
// ============================================================================
package b01_pkg;

    // Assembly FSM states: IDLE means no partial word is held.
    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_ASSEMBLE = 1'b1
    } state_e;

    localparam int c_default_word_w    = 8;
    localparam int c_default_ovf_cnt_w = 4;

    // Increment that sticks at the all-ones value of a 'width'-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
        logic [31:0] v_max;
        v_max = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= v_max) ? v_max : (value + 32'd1);
    endfunction

endpackage : b01_pkg
`default_nettype wire

// File: rtl/b01_out_slot.sv
`default_nettype none
// ============================================================================
//  Module      : b01_out_slot
//  Description : One-entry valid/ready output register. A load is taken only
//                when the slot is free; a full slot drains on ready and may
//                be refilled in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module b01_out_slot
    import b01_pkg::*;
#(
    parameter int WORD_W = c_default_word_w
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_data,
    input  logic              i_ovf,
    input  logic              i_ready,
    output logic              o_free,
    output logic [WORD_W-1:0] o_data,
    output logic              o_ovf,
    output logic              o_valid
);

    logic              r_valid;
    logic [WORD_W-1:0] r_data;
    logic              r_ovf;

    // Slot can accept a word when empty or when the held word leaves this cycle.
    assign o_free  = !r_valid || i_ready;
    assign o_data  = r_data;
    assign o_ovf   = r_ovf;
    assign o_valid = r_valid;

    // Load on completion into a free slot, otherwise drain on handshake; data is kept after drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ovf   <= 1'b0;
        end else if (i_load && o_free) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_ovf   <= i_ovf;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule : b01_out_slot
`default_nettype wire

// File: rtl/b01_stream_packer.sv
`default_nettype none
// ============================================================================
//  Module      : b01_stream_packer
//  Description : Packs the b01 comparator's serial outp/overflw stream
//                LSB-first into WORD_W-bit words, presents them through a
//                one-entry valid/ready slot, counts overflow events
//                (saturating) and flags words dropped under backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module b01_stream_packer
    import b01_pkg::*;
#(
    parameter int WORD_W    = c_default_word_w,
    parameter int OVF_CNT_W = c_default_ovf_cnt_w
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic                 outp,
    input  logic                 overflw,
    input  logic                 clear,
    output logic [WORD_W-1:0]    word_data,
    output logic                 word_ovf,
    output logic                 word_valid,
    input  logic                 word_ready,
    output logic [OVF_CNT_W-1:0] ovf_count,
    output logic                 drop_flag,
    output logic                 busy
);

    localparam int                 c_cnt_w    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [c_cnt_w-1:0] c_last_idx = c_cnt_w'(WORD_W - 1);
    localparam logic [0:0]         c_st_idle  = ST_IDLE;
    localparam logic [0:0]         c_st_asm   = ST_ASSEMBLE;

    logic [0:0]           r_state;
    logic [c_cnt_w-1:0]   r_bit_cnt;
    logic [WORD_W-1:0]    r_shift;
    logic                 r_ovf_acc;
    logic [OVF_CNT_W-1:0] r_ovf_count;
    logic                 r_drop;

    logic                 w_accept;
    logic                 w_complete;
    logic                 w_slot_free;
    logic [WORD_W-1:0]    w_shift_next;
    logic                 w_ovf_next;

    // A bit is taken whenever it is offered and no soft clear is pending.
    assign w_accept   = in_valid && !clear;
    assign w_complete = w_accept && (r_bit_cnt == c_last_idx);
    assign w_ovf_next = r_ovf_acc | overflw;

    // Insert the incoming bit at the current fill position of the word.
    always_comb begin
        w_shift_next            = r_shift;
        w_shift_next[r_bit_cnt] = outp;
    end

    // Assembly FSM: fill bit positions, return to IDLE once the word is complete.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= c_st_idle;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_ovf_acc <= 1'b0;
        end else if (clear) begin
            r_state   <= c_st_idle;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_ovf_acc <= 1'b0;
        end else if (w_accept) begin
            if (w_complete) begin
                r_state   <= c_st_idle;
                r_bit_cnt <= '0;
                r_shift   <= '0;
                r_ovf_acc <= 1'b0;
            end else begin
                r_state   <= c_st_asm;
                r_bit_cnt <= r_bit_cnt + 1'b1;
                r_shift   <= w_shift_next;
                r_ovf_acc <= w_ovf_next;
            end
        end
    end

    // Statistics: saturating overflow-event count and sticky drop indication.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ovf_count <= '0;
            r_drop      <= 1'b0;
        end else if (clear) begin
            r_ovf_count <= '0;
            r_drop      <= 1'b0;
        end else begin
            if (w_accept && overflw) begin
                r_ovf_count <= OVF_CNT_W'(sat_inc(32'(r_ovf_count), OVF_CNT_W));
            end
            if (w_complete && !w_slot_free) begin
                r_drop <= 1'b1;
            end
        end
    end

    // The completed word is offered to the slot; it is lost if the slot is still occupied.
    b01_out_slot #(
        .WORD_W (WORD_W)
    ) u_out_slot (
        .clk     (clock),
        .rst_n   (reset),
        .i_load  (w_complete),
        .i_data  (w_shift_next),
        .i_ovf   (w_ovf_next),
        .i_ready (word_ready),
        .o_free  (w_slot_free),
        .o_data  (word_data),
        .o_ovf   (word_ovf),
        .o_valid (word_valid)
    );

    assign ovf_count = r_ovf_count;
    assign drop_flag = r_drop;
    assign busy      = (r_state == c_st_asm);

endmodule : b01_stream_packer
`default_nettype wire
